// File: rtl/dht11_pkg.sv
// Shared DHT11 protocol definitions: timing defaults, state encoding and the frame checksum.
package dht11_pkg;

  localparam int unsigned START_MIN_US_DEF = 18000;
  localparam int unsigned WAIT_US_DEF      = 30;
  localparam int unsigned RESP_LOW_US_DEF  = 80;
  localparam int unsigned RESP_HIGH_US_DEF = 80;
  localparam int unsigned BIT_LOW_US_DEF   = 50;
  localparam int unsigned BIT0_HIGH_US_DEF = 26;
  localparam int unsigned BIT1_HIGH_US_DEF = 70;
  localparam int unsigned END_LOW_US_DEF   = 50;

  localparam int CNT_W      = 15;
  localparam int BIT_IDX_W  = 6;
  localparam int FRAME_BITS = 40;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOST_LOW  = 3'd1,
    WAIT_REL  = 3'd2,
    RESP_LOW  = 3'd3,
    RESP_HIGH = 3'd4,
    BIT_LOW   = 3'd5,
    BIT_HIGH  = 3'd6,
    END_LOW   = 3'd7
  } dht_state_e;

  function automatic logic [7:0] dht_checksum(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Two-flop synchronizer for the open-drain DHT line with rise/fall detection on synced samples.
module dht11_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: detects the host start pulse and transmits a 40-bit frame.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned START_MIN_US = START_MIN_US_DEF,
  parameter int unsigned WAIT_US      = WAIT_US_DEF,
  parameter int unsigned RESP_LOW_US  = RESP_LOW_US_DEF,
  parameter int unsigned RESP_HIGH_US = RESP_HIGH_US_DEF,
  parameter int unsigned BIT_LOW_US   = BIT_LOW_US_DEF,
  parameter int unsigned BIT0_HIGH_US = BIT0_HIGH_US_DEF,
  parameter int unsigned BIT1_HIGH_US = BIT1_HIGH_US_DEF,
  parameter int unsigned END_LOW_US   = END_LOW_US_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick_1us,
  input  logic       i_dht_in,
  input  logic [7:0] i_humid_int,
  input  logic [7:0] i_humid_dec,
  input  logic [7:0] i_temp_int,
  input  logic [7:0] i_temp_dec,
  output logic       o_dht_oe,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_short_start
);

  localparam logic [CNT_W:0]         START_MIN = (CNT_W+1)'(START_MIN_US);
  localparam logic [CNT_W-1:0]       WAIT_LAST = CNT_W'(WAIT_US - 1);
  localparam logic [CNT_W-1:0]       RLOW_LAST = CNT_W'(RESP_LOW_US - 1);
  localparam logic [CNT_W-1:0]       RHI_LAST  = CNT_W'(RESP_HIGH_US - 1);
  localparam logic [CNT_W-1:0]       BLOW_LAST = CNT_W'(BIT_LOW_US - 1);
  localparam logic [CNT_W-1:0]       B0_LAST   = CNT_W'(BIT0_HIGH_US - 1);
  localparam logic [CNT_W-1:0]       B1_LAST   = CNT_W'(BIT1_HIGH_US - 1);
  localparam logic [CNT_W-1:0]       ELOW_LAST = CNT_W'(END_LOW_US - 1);
  localparam logic [BIT_IDX_W-1:0]   LAST_BIT  = BIT_IDX_W'(FRAME_BITS - 1);

  dht_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0]     frame_q, frame_d;
  logic                      oe_q, oe_d;
  logic                      done_q, done_d;
  logic                      short_q, short_d;
  logic                      line_rise, line_fall;
  logic                      cur_bit, phase_end;
  logic [CNT_W-1:0]          phase_last;
  logic [CNT_W:0]            host_ticks;

  dht11_line_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .line_i (i_dht_in),
    .rise_o (line_rise),
    .fall_o (line_fall)
  );

  assign cur_bit = frame_q[LAST_BIT - bit_q];

  // The tick of the fall-detect cycle is spent in IDLE; the rise-cycle tick stands in for it.
  assign host_ticks = {1'b0, cnt_q} + (CNT_W+1)'(i_tick_1us);

  always_comb begin
    phase_last = '0;
    case (state_q)
      WAIT_REL:  phase_last = WAIT_LAST;
      RESP_LOW:  phase_last = RLOW_LAST;
      RESP_HIGH: phase_last = RHI_LAST;
      BIT_LOW:   phase_last = BLOW_LAST;
      BIT_HIGH:  phase_last = cur_bit ? B1_LAST : B0_LAST;
      END_LOW:   phase_last = ELOW_LAST;
      default:   phase_last = '0;
    endcase
  end

  assign phase_end = i_tick_1us && (cnt_q == phase_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    short_d = 1'b0;
    case (state_q)
      IDLE:     if (line_fall) state_d = HOST_LOW;
      HOST_LOW: if (line_rise) begin
        if (host_ticks >= START_MIN) state_d = WAIT_REL;
        else begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      WAIT_REL:  if (phase_end) state_d = RESP_LOW;
      RESP_LOW:  if (phase_end) state_d = RESP_HIGH;
      RESP_HIGH: if (phase_end) state_d = BIT_LOW;
      BIT_LOW:   if (phase_end) state_d = BIT_HIGH;
      BIT_HIGH:  if (phase_end) begin
        if (bit_q == LAST_BIT) state_d = END_LOW;
        else begin
          bit_d   = bit_q + 1'b1;
          state_d = BIT_LOW;
        end
      end
      END_LOW: if (phase_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (i_tick_1us) begin
      if (state_q == HOST_LOW) begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else if (state_q != IDLE) cnt_d = cnt_q + 1'b1;
    end

    // Snapshot the measurement so later input changes cannot corrupt the frame in flight.
    if (state_d == RESP_LOW && state_q != RESP_LOW) begin
      frame_d = {i_humid_int, i_humid_dec, i_temp_int, i_temp_dec,
                 dht_checksum(i_humid_int, i_humid_dec, i_temp_int, i_temp_dec)};
      bit_d   = '0;
    end

    oe_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      short_q <= short_d;
    end
  end

  assign o_dht_oe      = oe_q;
  assign o_busy        = (state_q != IDLE);
  assign o_frame_done  = done_q;
  assign o_short_start = short_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: host start pulses, frame decoding from o_dht_oe, reset cases.
module tb_dht11_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b1;
  logic       dht = 1'b1;
  logic [7:0] hi, hd, ti, td;
  logic       oe, busy, done, short_s;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int short_cnt = 0;
  int oe_hi_cnt = 0;

  int rise_n, rl, rh, el, bad_w, n70, n26, aborted, d0;
  logic [39:0] bits;

  dht11_responder dut (
    .clk           (clk),
    .reset         (reset),
    .i_tick_1us    (tick),
    .i_dht_in      (dht),
    .i_humid_int   (hi),
    .i_humid_dec   (hd),
    .i_temp_int    (ti),
    .i_temp_dec    (td),
    .o_dht_oe      (oe),
    .o_busy        (busy),
    .o_frame_done  (done),
    .o_short_start (short_s)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)    done_cnt  <= done_cnt + 1;
    if (short_s) short_cnt <= short_cnt + 1;
    if (oe)      oe_hi_cnt <= oe_hi_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_start(input int low_ticks);
    @(negedge clk);
    dht = 1'b0;
    repeat (low_ticks) @(negedge clk);
    dht = 1'b1;
  endtask

  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (oe === lvl && len < 1000) begin
      len++;
      @(negedge clk);
    end
  endtask

  // Called at the release negedge; decodes the frame from the oe waveform.
  task automatic get_frame(input int pause, input int chg_bit, input int abort_bit);
    int len;
    rise_n = 0; rl = 0; rh = 0; el = 0; bad_w = 0; n70 = 0; n26 = 0; aborted = 0;
    bits = '0;
    while (rise_n < 200) begin
      @(negedge clk);
      rise_n++;
      if (oe) break;
      tick = !(pause > 0 && rise_n >= 10 && rise_n < 10 + pause);
    end
    tick = 1'b1;
    if (!oe) return;
    run_len(1'b1, rl);
    run_len(1'b0, rh);
    for (int i = 0; i < 40; i++) begin
      if (i == chg_bit) begin
        hi = 8'h00; hd = 8'h00; ti = 8'h00; td = 8'h00;
      end
      run_len(1'b1, len);
      if (len != 50) bad_w++;
      if (i == abort_bit) begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        aborted = 1;
        return;
      end
      run_len(1'b0, len);
      if (len == 70) begin
        bits[39-i] = 1'b1;
        n70++;
      end else if (len == 26) n26++;
      else bad_w++;
    end
    run_len(1'b1, el);
  endtask

  initial begin
    hi = 8'h37; hd = 8'h00; ti = 8'h19; td = 8'h00;

    // Reset held: line toggles must have no effect
    repeat (3) @(negedge clk);
    dht = 1'b0;
    repeat (3) @(negedge clk);
    dht = 1'b1;
    repeat (2) @(negedge clk);
    dht = 1'b0;
    repeat (2) @(negedge clk);
    dht = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rst_oe", oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_cnt, 0);
    check("rst_short", short_cnt, 0);
    check("rst_oe_seen", oe_hi_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Short start: 17999 ticks low
    @(negedge clk);
    dht = 1'b0;
    repeat (100) @(negedge clk);
    check("short_busy_mid", busy, 1);
    repeat (17899) @(negedge clk);
    dht = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    check("short_pulse", short_cnt, 1);
    check("short_oe_seen", oe_hi_cnt, 0);
    check("short_busy", busy, 0);
    check("short_done", done_cnt, 0);

    // Reset during BIT_HIGH of bit 20
    host_start(18000);
    get_frame(0, -1, 20);
    #1;
    check("abort_hit", aborted, 1);
    check("abort_oe", oe, 0);
    check("abort_busy", busy, 0);
    check("abort_rise", rise_n, 33);
    check("abort_resp_low", rl, 80);
    check("abort_resp_high", rh, 80);
    check("abort_bits", bits[39:20], 20'h37001);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);

    // Nominal frame after the abort
    d0 = done_cnt;
    host_start(18000);
    get_frame(0, -1, -1);
    check("nom_rise", rise_n, 33);
    check("nom_resp_low", rl, 80);
    check("nom_resp_high", rh, 80);
    check("nom_bits", bits, 40'h3700190050);
    check("nom_widths", bad_w, 0);
    check("nom_end_low", el, 50);
    repeat (3) @(negedge clk);
    #1;
    check("nom_done", done_cnt, d0 + 1);
    check("nom_busy", busy, 0);
    check("nom_oe", oe, 0);

    // Checksum wrap, tick pause in WAIT_REL, inputs cleared at bit 5
    hi = 8'hFF; hd = 8'hFF; ti = 8'hFF; td = 8'hFF;
    d0 = done_cnt;
    host_start(18000);
    get_frame(5, 5, -1);
    check("ff_rise_paused", rise_n, 38);
    check("ff_bits", bits, 40'hFFFFFFFFFC);
    check("ff_n70", n70, 38);
    check("ff_n26", n26, 2);
    check("ff_widths", bad_w, 0);
    check("ff_end_low", el, 50);
    repeat (3) @(negedge clk);
    #1;
    check("ff_done", done_cnt, d0 + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
